// File: rtl/fir_pkg.sv
// Shared definitions for the sequential FIR and its output requantiser.
package fir_pkg;

  localparam int FIR_OUT_W = 33;
  localparam int SAMPLE_W  = 16;

  localparam logic signed [SAMPLE_W-1:0] MAX_S = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] MIN_S = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef struct packed {
    logic                       sat;
    logic signed [SAMPLE_W-1:0] val;
  } clamp_t;

  // Clamp a (FIR_OUT_W+1)-bit value into a SAMPLE_W sample, flagging any clip.
  function automatic clamp_t sat_clamp(input logic signed [FIR_OUT_W:0] q);
    clamp_t res;
    res.sat = 1'b1;
    if (q > MAX_S)      res.val = MAX_S;
    else if (q < MIN_S) res.val = MIN_S;
    else begin
      res.sat = 1'b0;
      res.val = q[SAMPLE_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with a registered head word; full writes are
// accepted only when a pop happens in the same cycle.
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
  logic [CW-1:0]    r_count, w_cnt_nxt;
  logic [WIDTH-1:0] r_rd_data, w_head_nxt;
  logic             w_pop, w_push;

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign w_pop  = rd_en && !empty;
  assign w_push = wr_en && (!full || w_pop);

  assign w_cnt_nxt    = r_count + CW'(w_push) - CW'(w_pop);
  assign w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
  // Nothing left after the pop means the incoming word becomes the new head.
  assign w_head_nxt   = (r_count == CW'(w_pop)) ? wr_data : r_mem[w_rd_ptr_nxt];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_cnt_nxt;
      if (w_cnt_nxt != '0) r_rd_data <= w_head_nxt;
    end
  end

  assign rd_data = r_rd_data;
  assign count   = r_count;

endmodule

// File: rtl/fir_out_requant.sv
// FIR output requantiser: decimate, round half-up, shift, saturate, then
// buffer in a FWFT FIFO with sticky saturation/overflow flags.
module fir_out_requant
  import fir_pkg::*;
#(
  parameter int IN_W  = FIR_OUT_W,
  parameter int OUT_W = SAMPLE_W,
  parameter int SHIFT = 15,
  parameter int DECIM = 1,
  parameter int DEPTH = 4
) (
  input  logic                   sclk,
  input  logic                   s_rst_n,
  input  logic [IN_W-1:0]        din,
  input  logic                   din_vld,
  output logic [OUT_W-1:0]       dout,
  output logic                   dout_vld,
  input  logic                   dout_rdy,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   sat_flag,
  output logic                   ovf_flag,
  input  logic                   clr_flags
);

  localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
  // Half an output LSB; collapses to zero when SHIFT is 0.
  localparam logic signed [IN_W:0] RND  = ((IN_W+1)'(1) << SHIFT) >> 1;
  localparam logic signed [IN_W:0] QMAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] QMIN = ~QMAX;

  function automatic logic signed [IN_W:0] round_add(input logic signed [IN_W-1:0] x);
    return $signed({x[IN_W-1], x}) + RND;
  endfunction

  function automatic logic is_sat(input logic signed [IN_W:0] q);
    return (q > QMAX) || (q < QMIN);
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [IN_W:0] q);
    if (q > QMAX) return QMAX[OUT_W-1:0];
    if (q < QMIN) return QMIN[OUT_W-1:0];
    return q[OUT_W-1:0];
  endfunction

  logic [DCW-1:0]          r_dcnt;
  logic                    w_keep;
  logic signed [IN_W:0]    r_sum_p1, w_q_p1;
  logic                    r_vld_p1, r_vld_p2;
  logic signed [OUT_W-1:0] r_q_p2;
  logic                    r_sat, r_ovf;
  logic                    w_empty, w_full, w_pop, w_sat_evt, w_ovf_evt;

  assign w_keep = din_vld && (r_dcnt == '0);

  always_ff @(posedge sclk) begin
    if (!s_rst_n)     r_dcnt <= '0;
    else if (din_vld) r_dcnt <= (r_dcnt == DCW'(DECIM-1)) ? '0 : r_dcnt + 1'b1;
  end

  // S1: widen and add the rounding constant
  always_ff @(posedge sclk) begin
    if (!s_rst_n) r_vld_p1 <= 1'b0;
    else          r_vld_p1 <= w_keep;
  end

  always_ff @(posedge sclk) begin
    if (w_keep) r_sum_p1 <= round_add($signed(din));
  end

  // S2: arithmetic shift and clamp
  assign w_q_p1    = r_sum_p1 >>> SHIFT;
  assign w_sat_evt = r_vld_p1 && is_sat(w_q_p1);

  always_ff @(posedge sclk) begin
    if (!s_rst_n) r_vld_p2 <= 1'b0;
    else          r_vld_p2 <= r_vld_p1;
  end

  always_ff @(posedge sclk) begin
    if (r_vld_p1) r_q_p2 <= saturate(w_q_p1);
  end

  // FIFO write stage; a set event beats a same-cycle clear
  assign w_pop     = dout_rdy && !w_empty;
  assign w_ovf_evt = r_vld_p2 && w_full && !w_pop;

  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      r_sat <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_sat <= w_sat_evt || (r_sat && !clr_flags);
      r_ovf <= w_ovf_evt || (r_ovf && !clr_flags);
    end
  end

  sync_fifo_fwft #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (sclk),
    .rst_n   (s_rst_n),
    .wr_en   (r_vld_p2),
    .wr_data (r_q_p2),
    .rd_en   (dout_rdy),
    .rd_data (dout),
    .empty   (w_empty),
    .full    (w_full),
    .count   (fifo_cnt)
  );

  assign dout_vld = !w_empty;
  assign sat_flag = r_sat;
  assign ovf_flag = r_ovf;

endmodule
